// File: rtl/dataflow_mc.sv
// Multicycle RV integer datapath + IDLE/DECODE/EXEC/WB sequencer; `define DATAFLOW_SLT_EN adds SLT/SLTU/SLTI/SLTIU.
// Retires 4 cycles after acceptance; instr_ready is low while an instruction is in flight.
module dataflow_mc #(
    parameter int              XLEN     = 64,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int         AW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_LUI, OP_SLT, OP_SLTU,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGEU, OP_JAL
    } op_t;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < NREG_L;
    endfunction

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0] res_q, res_d, npc_q, npc_d;
    logic            ill_q, ill_d, wen_q, wen_d;
    logic            retire_q, retire_d, illegal_q, illegal_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j, rs1_val, rs2_val;

    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign funct3  = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign funct7  = instr_q[31:25];
    assign imm_i   = XLEN'($signed(instr_q[31:20]));
    assign imm_b   = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({instr_q[31:12], 12'b0}));
    assign imm_j   = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
    assign rs1_val = rf_q[rs1[AW-1:0]];
    assign rs2_val = rf_q[rs2[AW-1:0]];

    // Decode: out-of-range register fields only matter for the fields the format actually uses.
    op_t             dec_op;
    logic [XLEN-1:0] dec_b, dec_imm;
    logic            dec_ill;

    always_comb begin
        dec_op  = OP_ADD;
        dec_b   = rs2_val;
        dec_imm = imm_i;
        dec_ill = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_b   = imm_i;
                dec_ill = !idx_ok(rd) || !idx_ok(rs1);
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
`ifdef DATAFLOW_SLT_EN
                    3'b010:  dec_op = OP_SLT;
                    3'b011:  dec_op = OP_SLTU;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0110011: begin
                dec_ill = !idx_ok(rd) || !idx_ok(rs1) || !idx_ok(rs2);
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_op = OP_ADD;
                    {7'h20, 3'b000}: dec_op = OP_SUB;
`ifdef DATAFLOW_SLT_EN
                    {7'h00, 3'b010}: dec_op = OP_SLT;
                    {7'h00, 3'b011}: dec_op = OP_SLTU;
`endif
                    default:         dec_ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec_op  = OP_LUI;
                dec_imm = imm_u;
                dec_ill = !idx_ok(rd);
            end
            7'b1100011: begin
                dec_imm = imm_b;
                dec_ill = !idx_ok(rs1) || !idx_ok(rs2);
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                dec_op  = OP_JAL;
                dec_imm = imm_j;
                dec_ill = !idx_ok(rd);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Execute: one shared comparator serves both branches and SLT*.
    logic            cmp_eq, cmp_lt, cmp_ltu, ex_wen;
    logic [XLEN-1:0] ex_res, ex_npc, pc_plus4, pc_target;

    assign cmp_eq    = (a_q == b_q);
    assign cmp_lt    = ($signed(a_q) < $signed(b_q));
    assign cmp_ltu   = (a_q < b_q);
    assign pc_plus4  = pc_q + XLEN'(4);
    assign pc_target = pc_q + imm_q;

    always_comb begin
        ex_res = a_q + b_q;
        ex_npc = pc_plus4;
        ex_wen = 1'b1;
        case (op_q)
            OP_SUB:  ex_res = a_q - b_q;
            OP_LUI:  ex_res = imm_q;
            OP_SLT:  ex_res = XLEN'(cmp_lt);
            OP_SLTU: ex_res = XLEN'(cmp_ltu);
            OP_BEQ:  begin ex_wen = 1'b0; ex_npc = cmp_eq   ? pc_target : pc_plus4; end
            OP_BNE:  begin ex_wen = 1'b0; ex_npc = !cmp_eq  ? pc_target : pc_plus4; end
            OP_BLT:  begin ex_wen = 1'b0; ex_npc = cmp_lt   ? pc_target : pc_plus4; end
            OP_BGEU: begin ex_wen = 1'b0; ex_npc = !cmp_ltu ? pc_target : pc_plus4; end
            OP_JAL:  begin ex_res = pc_plus4; ex_npc = pc_target; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        ill_d     = ill_q;
        res_d     = res_q;
        npc_d     = npc_q;
        wen_d     = wen_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rd[AW-1:0];
        rf_wdata  = res_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = dec_op;
                a_d     = rs1_val;
                b_d     = dec_b;
                imm_d   = dec_imm;
                ill_d   = dec_ill;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = ex_res;
                npc_d   = ex_npc;
                wen_d   = ex_wen;
                state_d = S_WB;
            end
            default: begin
                if (ill_q) begin
                    illegal_d = 1'b1;
                end else begin
                    retire_d = 1'b1;
                    pc_d     = npc_q;
                    rf_we    = wen_q && (rd != 5'd0);
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            pc_q      <= PC_RESET;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            ill_q     <= 1'b0;
            res_q     <= '0;
            npc_q     <= '0;
            wen_q     <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            ill_q     <= ill_d;
            res_q     <= res_d;
            npc_q     <= npc_d;
            wen_q     <= wen_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr != 5'd0 && idx_ok(dbg_addr)) dbg_data = rf_q[dbg_addr[AW-1:0]];
    end

    assign instr_ready = (state_q == S_IDLE);
    assign pc          = pc_q;
    assign retire      = retire_q;
    assign illegal     = illegal_q;

endmodule
